// File: rtl/wash_phase_sequencer.sv
// Washer programme sequencer: walks the enabled wash/rinse/dry phases through
// fill/agitate/drain/spin on 1 Hz ticks, with pause, lid interlock and a done alarm.
module wash_phase_sequencer #(
   parameter int unsigned FILL_T  = 3,
   parameter int unsigned WASH_T  = 9,
   parameter int unsigned RINSE_T = 6,
   parameter int unsigned DRAIN_T = 3,
   parameter int unsigned SPIN_T  = 3,
   parameter int unsigned ALARM_T = 5
) (
   input  logic       cp,
   input  logic       resetBtn,
   input  logic       runBtn,
   input  logic       openBtn,
   input  logic       tick,
   input  logic [2:0] mode,
   input  logic [2:0] waterLevel,
   output logic [1:0] phase,
   output logic [1:0] step,
   output logic       inWater,
   output logic       agitate,
   output logic       outWater,
   output logic       spin,
   output logic [7:0] remain,
   output logic [7:0] stepRemain,
   output logic       running,
   output logic       paused,
   output logic       done
);

   localparam int unsigned CW = 8;

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_AGIT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_SPIN  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_e;

   function automatic logic [2:0] clamp_lvl(input logic [2:0] l);
      if (l == 3'd0)      return 3'd1;
      else if (l > 3'd5)  return 3'd5;
      else                return l;
   endfunction

   // Phase p (1 wash, 2 rinse, 3 dry) maps to mode bit [3-p].
   function automatic logic phase_en(input logic [2:0] m, input logic [1:0] p);
      case (p)
         2'd1:    return m[2];
         2'd2:    return m[1];
         2'd3:    return m[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [CW-1:0] step_dur(input logic [1:0] p, input logic [1:0] s,
                                             input logic [2:0] l);
      case (s)
         ST_FILL:  return CW'(FILL_T * 32'(l));
         ST_AGIT:  return (p == 2'd1) ? CW'(WASH_T) : CW'(RINSE_T);
         ST_DRAIN: return CW'(DRAIN_T);
         default:  return CW'(SPIN_T);
      endcase
   endfunction

   function automatic logic [CW-1:0] phase_total(input logic [1:0] p, input logic [2:0] m,
                                                input logic [2:0] l);
      if (!phase_en(m, p))
         return '0;
      else if (p == 2'd3)
         return step_dur(p, ST_DRAIN, l) + step_dur(p, ST_SPIN, l);
      else
         return step_dur(p, ST_FILL, l) + step_dur(p, ST_AGIT, l)
              + step_dur(p, ST_DRAIN, l) + step_dur(p, ST_SPIN, l);
   endfunction

   // Returns {found, phase, step} of the step after (p, s); p=0/s=SPIN yields the first step.
   function automatic logic [4:0] next_pos(input logic [1:0] p, input logic [1:0] s,
                                           input logic [2:0] m);
      logic [4:0] r;
      r = '0;
      if (p != 2'd0 && s != ST_SPIN) begin
         r = {1'b1, p, s + 2'd1};
      end else begin
         for (int q = 3; q >= 1; q--) begin
            if (q > int'(p) && phase_en(m, 2'(q)))
               r = {1'b1, 2'(q), (q == 3) ? ST_DRAIN : ST_FILL};
         end
      end
      return r;
   endfunction

   state_e        state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [1:0]    step_q, step_d;
   logic [CW-1:0] remain_q, remain_d;
   logic [CW-1:0] step_remain_q, step_remain_d;
   logic [CW-1:0] alarm_cnt_q, alarm_cnt_d;
   logic [2:0]    mode_q, mode_d;
   logic [2:0]    lvl_q, lvl_d;
   logic          in_water_q, in_water_d;
   logic          agitate_q, agitate_d;
   logic          out_water_q, out_water_d;
   logic          spin_q, spin_d;
   logic          running_q, running_d;
   logic          paused_q, paused_d;
   logic          done_q, done_d;
   logic [4:0]    nxt_pos;

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      step_d        = step_q;
      remain_d      = remain_q;
      step_remain_d = step_remain_q;
      alarm_cnt_d   = alarm_cnt_q;
      mode_d        = mode_q;
      lvl_d         = lvl_q;
      nxt_pos       = '0;

      case (state_q)
         S_IDLE: begin
            if (runBtn && mode != 3'd0 && !openBtn) begin
               mode_d        = mode;
               lvl_d         = clamp_lvl(waterLevel);
               nxt_pos       = next_pos(2'd0, ST_SPIN, mode);
               phase_d       = nxt_pos[3:2];
               step_d        = nxt_pos[1:0];
               step_remain_d = step_dur(nxt_pos[3:2], nxt_pos[1:0], lvl_d);
               remain_d      = phase_total(2'd1, mode, lvl_d) + phase_total(2'd2, mode, lvl_d)
                             + phase_total(2'd3, mode, lvl_d);
               state_d       = S_RUN;
            end
         end
         S_RUN: begin
            // Pause requests win over a coincident tick, which is dropped.
            if (runBtn || openBtn) begin
               state_d = S_PAUSE;
            end else if (tick) begin
               remain_d = (remain_q != '0) ? remain_q - CW'(1) : '0;
               if (step_remain_q <= CW'(1)) begin
                  nxt_pos = next_pos(phase_q, step_q, mode_q);
                  if (nxt_pos[4]) begin
                     phase_d       = nxt_pos[3:2];
                     step_d        = nxt_pos[1:0];
                     step_remain_d = step_dur(nxt_pos[3:2], nxt_pos[1:0], lvl_q);
                  end else begin
                     state_d       = S_ALARM;
                     alarm_cnt_d   = CW'(ALARM_T);
                     phase_d       = 2'd0;
                     step_d        = 2'd0;
                     remain_d      = '0;
                     step_remain_d = '0;
                  end
               end else begin
                  step_remain_d = step_remain_q - CW'(1);
               end
            end
         end
         S_PAUSE: begin
            if (runBtn && !openBtn)
               state_d = S_RUN;
         end
         default: begin
            if (runBtn) begin
               state_d     = S_IDLE;
               alarm_cnt_d = '0;
            end else if (tick) begin
               if (alarm_cnt_q <= CW'(1)) begin
                  state_d     = S_IDLE;
                  alarm_cnt_d = '0;
               end else begin
                  alarm_cnt_d = alarm_cnt_q - CW'(1);
               end
            end
         end
      endcase

      running_d   = (state_d == S_RUN);
      paused_d    = (state_d == S_PAUSE);
      done_d      = (state_d == S_ALARM);
      in_water_d  = running_d && (step_d == ST_FILL);
      agitate_d   = running_d && (step_d == ST_AGIT);
      out_water_d = running_d && (step_d == ST_DRAIN);
      spin_d      = running_d && (step_d == ST_SPIN);
   end

   always_ff @(posedge cp) begin
      if (resetBtn) begin
         state_q       <= S_IDLE;
         phase_q       <= '0;
         step_q        <= '0;
         remain_q      <= '0;
         step_remain_q <= '0;
         alarm_cnt_q   <= '0;
         mode_q        <= '0;
         lvl_q         <= '0;
         in_water_q    <= 1'b0;
         agitate_q     <= 1'b0;
         out_water_q   <= 1'b0;
         spin_q        <= 1'b0;
         running_q     <= 1'b0;
         paused_q      <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         step_q        <= step_d;
         remain_q      <= remain_d;
         step_remain_q <= step_remain_d;
         alarm_cnt_q   <= alarm_cnt_d;
         mode_q        <= mode_d;
         lvl_q         <= lvl_d;
         in_water_q    <= in_water_d;
         agitate_q     <= agitate_d;
         out_water_q   <= out_water_d;
         spin_q        <= spin_d;
         running_q     <= running_d;
         paused_q      <= paused_d;
         done_q        <= done_d;
      end
   end

   assign phase      = phase_q;
   assign step       = step_q;
   assign remain     = remain_q;
   assign stepRemain = step_remain_q;
   assign inWater    = in_water_q;
   assign agitate    = agitate_q;
   assign outWater   = out_water_q;
   assign spin       = spin_q;
   assign running    = running_q;
   assign paused     = paused_q;
   assign done       = done_q;

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Directed bench for wash_phase_sequencer: a per-cycle vector table plus
// hand-written sequences for full programmes, alarm timeout and mid-run reset.
module tb_wash_phase_sequencer;

   logic       cp = 1'b0;
   logic       resetBtn = 1'b0, runBtn = 1'b0, openBtn = 1'b0, tick = 1'b0;
   logic [2:0] mode = '0, waterLevel = '0;
   logic [1:0] phase, step;
   logic       inWater, agitate, outWater, spin;
   logic [7:0] remain, stepRemain;
   logic       running, paused, done;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic       run;
      logic       pau;
      logic       dn;
      logic [1:0] ph;
      logic [1:0] st;
      logic [3:0] act;   // {inWater, agitate, outWater, spin}
      logic [7:0] rem;
      logic [7:0] srem;
   } out_t;

   typedef struct {
      logic       rst;
      logic       run;
      logic       open;
      logic       tk;
      logic [2:0] md;
      logic [2:0] lvl;
      out_t       exp;
   } vec_t;

   localparam int NV = 19;
   vec_t vt [NV];

   wash_phase_sequencer dut (
      .cp(cp), .resetBtn(resetBtn), .runBtn(runBtn), .openBtn(openBtn), .tick(tick),
      .mode(mode), .waterLevel(waterLevel), .phase(phase), .step(step),
      .inWater(inWater), .agitate(agitate), .outWater(outWater), .spin(spin),
      .remain(remain), .stepRemain(stepRemain),
      .running(running), .paused(paused), .done(done)
   );

   always #5 cp = ~cp;

   function automatic out_t mko(input logic r, input logic p, input logic d,
                                input logic [1:0] ph, input logic [1:0] st,
                                input logic [3:0] act, input logic [7:0] rem,
                                input logic [7:0] srem);
      out_t o;
      o = '{run: r, pau: p, dn: d, ph: ph, st: st, act: act, rem: rem, srem: srem};
      return o;
   endfunction

   function automatic vec_t mkv(input logic rst, input logic run, input logic open,
                                input logic tk, input logic [2:0] md, input logic [2:0] lvl,
                                input out_t exp);
      vec_t v;
      v.rst = rst; v.run = run; v.open = open; v.tk = tk;
      v.md = md; v.lvl = lvl; v.exp = exp;
      return v;
   endfunction

   task automatic apply(input logic r, input logic rb, input logic ob, input logic tk);
      resetBtn = r;
      runBtn   = rb;
      openBtn  = ob;
      tick     = tk;
      @(posedge cp);
      #1;
      resetBtn = 1'b0;
      runBtn   = 1'b0;
      tick     = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic check(input string name, input out_t e);
      out_t a;
      a = '{run: running, pau: paused, dn: done, ph: phase, st: step,
            act: {inWater, agitate, outWater, spin}, rem: remain, srem: stepRemain};
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got run=%0b pau=%0b done=%0b ph=%0d st=%0d act=%b rem=%0d srem=%0d | want run=%0b pau=%0b done=%0b ph=%0d st=%0d act=%b rem=%0d srem=%0d",
                  name, a.run, a.pau, a.dn, a.ph, a.st, a.act, a.rem, a.srem,
                  e.run, e.pau, e.dn, e.ph, e.st, e.act, e.rem, e.srem);
      end
   endtask

   initial begin
      out_t z;
      z = mko(0, 0, 0, 0, 0, 4'b0000, 0, 0);

      // rst run open tick mode lvl -> expected outputs after that edge
      vt[0]  = mkv(1, 0, 0, 0, 3'b000, 3'd0, z);
      vt[1]  = mkv(0, 1, 0, 0, 3'b000, 3'd2, z);
      vt[2]  = mkv(0, 1, 1, 0, 3'b100, 3'd2, z);
      vt[3]  = mkv(0, 1, 0, 0, 3'b100, 3'd2, mko(1, 0, 0, 1, 0, 4'b1000, 21, 6));
      vt[4]  = mkv(0, 0, 0, 1, 3'b100, 3'd2, mko(1, 0, 0, 1, 0, 4'b1000, 20, 5));
      vt[5]  = mkv(0, 0, 0, 1, 3'b111, 3'd5, mko(1, 0, 0, 1, 0, 4'b1000, 19, 4));
      vt[6]  = mkv(0, 0, 0, 0, 3'b111, 3'd5, mko(1, 0, 0, 1, 0, 4'b1000, 19, 4));
      vt[7]  = mkv(0, 0, 0, 1, 3'b111, 3'd5, mko(1, 0, 0, 1, 0, 4'b1000, 18, 3));
      vt[8]  = mkv(0, 0, 0, 1, 3'b111, 3'd5, mko(1, 0, 0, 1, 0, 4'b1000, 17, 2));
      vt[9]  = mkv(0, 0, 0, 1, 3'b111, 3'd5, mko(1, 0, 0, 1, 0, 4'b1000, 16, 1));
      vt[10] = mkv(0, 0, 0, 1, 3'b111, 3'd5, mko(1, 0, 0, 1, 1, 4'b0100, 15, 9));
      vt[11] = mkv(0, 0, 1, 1, 3'b111, 3'd5, mko(0, 1, 0, 1, 1, 4'b0000, 15, 9));
      vt[12] = mkv(0, 0, 1, 1, 3'b111, 3'd5, mko(0, 1, 0, 1, 1, 4'b0000, 15, 9));
      vt[13] = mkv(0, 1, 1, 0, 3'b111, 3'd5, mko(0, 1, 0, 1, 1, 4'b0000, 15, 9));
      vt[14] = mkv(0, 0, 0, 0, 3'b111, 3'd5, mko(0, 1, 0, 1, 1, 4'b0000, 15, 9));
      vt[15] = mkv(0, 1, 0, 0, 3'b111, 3'd5, mko(1, 0, 0, 1, 1, 4'b0100, 15, 9));
      vt[16] = mkv(0, 0, 0, 1, 3'b111, 3'd5, mko(1, 0, 0, 1, 1, 4'b0100, 14, 8));
      vt[17] = mkv(0, 1, 0, 1, 3'b111, 3'd5, mko(0, 1, 0, 1, 1, 4'b0000, 14, 8));
      vt[18] = mkv(0, 1, 0, 0, 3'b111, 3'd5, mko(1, 0, 0, 1, 1, 4'b0100, 14, 8));

      for (int i = 0; i < NV; i++) begin
         mode       = vt[i].md;
         waterLevel = vt[i].lvl;
         apply(vt[i].rst, vt[i].run, vt[i].open, vt[i].tk);
         check($sformatf("vec%0d", i), vt[i].exp);
      end

      // Finish the wash-only programme from agitate 14/8, then acknowledge the alarm.
      ticks(8);
      check("wash_drain", mko(1, 0, 0, 1, 2, 4'b0010, 6, 3));
      ticks(3);
      check("wash_spin", mko(1, 0, 0, 1, 3, 4'b0001, 3, 3));
      ticks(2);
      check("wash_spin_last", mko(1, 0, 0, 1, 3, 4'b0001, 1, 1));
      ticks(1);
      check("wash_alarm", mko(0, 0, 1, 0, 0, 4'b0000, 0, 0));
      apply(0, 1, 0, 0);
      check("alarm_ack", z);
      apply(0, 0, 0, 0);
      check("no_restart", z);

      // Full three-phase programme, level 0 clamps to 1, alarm times out.
      apply(1, 0, 0, 0);
      mode = 3'b111; waterLevel = 3'd0;
      apply(0, 1, 0, 0);
      check("all_start", mko(1, 0, 0, 1, 0, 4'b1000, 39, 3));
      ticks(17);
      check("all_wash_end", mko(1, 0, 0, 1, 3, 4'b0001, 22, 1));
      ticks(1);
      check("all_rinse", mko(1, 0, 0, 2, 0, 4'b1000, 21, 3));
      ticks(15);
      check("all_dry", mko(1, 0, 0, 3, 2, 4'b0010, 6, 3));
      ticks(6);
      check("all_done", mko(0, 0, 1, 0, 0, 4'b0000, 0, 0));
      ticks(4);
      check("alarm_hold", mko(0, 0, 1, 0, 0, 4'b0000, 0, 0));
      apply(0, 0, 0, 0);
      check("alarm_notick", mko(0, 0, 1, 0, 0, 4'b0000, 0, 0));
      ticks(1);
      check("alarm_timeout", z);

      // Rinse only at level 3; level change mid-run ignored; reset mid-run.
      mode = 3'b010; waterLevel = 3'd3;
      apply(0, 1, 0, 0);
      check("rinse_start", mko(1, 0, 0, 2, 0, 4'b1000, 21, 9));
      waterLevel = 3'd5;
      ticks(5);
      check("rinse_5ticks", mko(1, 0, 0, 2, 0, 4'b1000, 16, 4));
      apply(1, 0, 0, 0);
      check("midrun_reset", z);
      apply(0, 0, 0, 1);
      check("after_reset", z);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
